// File: rtl/dcache_memory_responder_pkg.sv
// Shared types and defaults for the D-cache memory-side responder.
package dcache_memory_responder_pkg;

    localparam int unsigned PHY_ADDR_WIDTH      = 32;
    localparam int unsigned DCACHE_LINE_WIDTH   = 128;
    localparam int unsigned MEM_SERIAL_WIDTH    = 4;
    localparam int unsigned MEM_INDEX_WIDTH     = 10;
    localparam int unsigned DEFAULT_QUEUE_DEPTH = 4;
    localparam int unsigned DEFAULT_MEM_LATENCY = 4;

    typedef logic [PHY_ADDR_WIDTH-1:0]    phy_addr_path_t;
    typedef logic [DCACHE_LINE_WIDTH-1:0] dcache_line_path_t;
    typedef logic [MEM_SERIAL_WIDTH-1:0]  mem_access_serial_t;
    typedef logic [MEM_SERIAL_WIDTH-1:0]  mem_write_serial_t;

    typedef struct packed {
        logic                       we;
        logic [MEM_INDEX_WIDTH-1:0] index;
        dcache_line_path_t          data;
        mem_access_serial_t         serial;
    } mem_responder_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESPOND
    } mem_responder_phase_e;

endpackage

// File: rtl/dcache_memory_responder_mem_request_queue.sv
// In-order circular request FIFO; also exposes the entry that will sit at the
// head next cycle so the service FSM can register its array drive one cycle early.
module mem_request_queue
    import dcache_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_QUEUE_DEPTH,
    parameter type         entry_t = mem_responder_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head_next_c,
    output logic                   nonempty_next_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // An entry survives this cycle's pop, otherwise the incoming one becomes head.
        head_next_c     = (count_q > CNT_W'(pop)) ? mem_q[rd_ptr_d] : push_data;
        nonempty_next_c = (count_d != '0);
        full_c          = (count_q == CNT_W'(DEPTH));
        empty_c         = (count_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;

endmodule

// File: rtl/dcache_memory_responder.sv
// Memory-side responder for the D-cache line-request channel: acks and tags
// requests, services them in order against a single-port line array.
module dcache_memory_responder
    import dcache_memory_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = PHY_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH   = DCACHE_LINE_WIDTH,
    parameter int unsigned OFFSET_BITS  = 4,
    parameter int unsigned INDEX_WIDTH  = MEM_INDEX_WIDTH,
    parameter int unsigned SERIAL_WIDTH = MEM_SERIAL_WIDTH,
    parameter int unsigned QUEUE_DEPTH  = DEFAULT_QUEUE_DEPTH,
    parameter int unsigned MEM_LATENCY  = DEFAULT_MEM_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    memValid,
    input  logic                    memWE,
    input  logic [ADDR_WIDTH-1:0]   memAddr,
    input  logic [LINE_WIDTH-1:0]   memData,
    output logic                    memReqAck,
    output logic [SERIAL_WIDTH-1:0] memSerial,
    output logic [SERIAL_WIDTH-1:0] memWSerial,
    output logic                    resultValid,
    output logic [SERIAL_WIDTH-1:0] resultSerial,
    output logic [LINE_WIDTH-1:0]   resultData,
    output logic                    responseValid,
    output logic [SERIAL_WIDTH-1:0] responseSerial,
    output logic [INDEX_WIDTH-1:0]  arrayIndex,
    output logic                    arrayWE,
    output logic [LINE_WIDTH-1:0]   arrayWData,
    input  logic [LINE_WIDTH-1:0]   arrayRData
);

    localparam int unsigned LAT_W = $clog2(MEM_LATENCY);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic                    we;
        logic [INDEX_WIDTH-1:0]  index;
        logic [LINE_WIDTH-1:0]   data;
        logic [SERIAL_WIDTH-1:0] serial;
    } entry_t;

    mem_responder_phase_e    phase_q, phase_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [SERIAL_WIDTH-1:0] rd_serial_q, rd_serial_d;
    logic [SERIAL_WIDTH-1:0] wr_serial_q, wr_serial_d;
    logic                    cur_we_q, cur_we_d;
    logic [SERIAL_WIDTH-1:0] cur_serial_q, cur_serial_d;
    logic [INDEX_WIDTH-1:0]  array_index_q, array_index_d;
    logic                    array_we_q, array_we_d;
    logic [LINE_WIDTH-1:0]   array_wdata_q, array_wdata_d;
    logic                    result_valid_q, result_valid_d;
    logic [SERIAL_WIDTH-1:0] result_serial_q, result_serial_d;
    logic [LINE_WIDTH-1:0]   result_data_q, result_data_d;
    logic                    response_valid_q, response_valid_d;
    logic [SERIAL_WIDTH-1:0] response_serial_q, response_serial_d;

    logic             push, pop, full_c, nonempty_next_c;
    entry_t           push_entry, head_next_c;
    logic [CNT_W-1:0] unused_count;
    logic             unused_empty, unused_addr;

    assign push = memValid && !full_c;
    assign pop  = (phase_q == RESPOND);

    assign push_entry = '{
        we:     memWE,
        index:  memAddr[OFFSET_BITS+INDEX_WIDTH-1:OFFSET_BITS],
        data:   memData,
        serial: memWE ? wr_serial_q : rd_serial_q
    };
    assign unused_addr = ^{memAddr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_WIDTH], memAddr[OFFSET_BITS-1:0]};

    mem_request_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk             (clk),
        .rst_n           (rst),
        .push            (push),
        .push_data       (push_entry),
        .pop             (pop),
        .head_next_c     (head_next_c),
        .nonempty_next_c (nonempty_next_c),
        .full_c          (full_c),
        .empty_c         (unused_empty),
        .count           (unused_count)
    );

    always_comb begin
        phase_d           = phase_q;
        lat_d             = lat_q;
        rd_serial_d       = rd_serial_q + SERIAL_WIDTH'(push && !memWE);
        wr_serial_d       = wr_serial_q + SERIAL_WIDTH'(push && memWE);
        cur_we_d          = cur_we_q;
        cur_serial_d      = cur_serial_q;
        array_index_d     = array_index_q;
        array_we_d        = 1'b0;
        array_wdata_d     = array_wdata_q;
        result_valid_d    = 1'b0;
        result_serial_d   = result_serial_q;
        result_data_d     = result_data_q;
        response_valid_d  = 1'b0;
        response_serial_d = response_serial_q;

        case (phase_q)
            IDLE: begin
                if (nonempty_next_c) phase_d = ACCESS;
            end
            ACCESS: begin
                lat_d   = LAT_W'(MEM_LATENCY - 1);
                phase_d = WAIT;
            end
            WAIT: begin
                // Registered array read data is valid in the first WAIT cycle only.
                if (!cur_we_q && lat_q == LAT_W'(MEM_LATENCY - 1)) result_data_d = arrayRData;
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) phase_d = RESPOND;
            end
            RESPOND: begin
                phase_d = nonempty_next_c ? ACCESS : IDLE;
            end
            default: phase_d = IDLE;
        endcase

        // Outputs are registered, so load them on the transition into their phase.
        if (phase_d == ACCESS) begin
            cur_we_d      = head_next_c.we;
            cur_serial_d  = head_next_c.serial;
            array_index_d = head_next_c.index;
            array_we_d    = head_next_c.we;
            if (head_next_c.we) array_wdata_d = head_next_c.data;
        end
        if (phase_d == RESPOND) begin
            result_valid_d   = !cur_we_q;
            response_valid_d = cur_we_q;
            if (cur_we_q) response_serial_d = cur_serial_q;
            else          result_serial_d   = cur_serial_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q           <= IDLE;
            lat_q             <= '0;
            rd_serial_q       <= '0;
            wr_serial_q       <= '0;
            cur_we_q          <= 1'b0;
            cur_serial_q      <= '0;
            array_index_q     <= '0;
            array_we_q        <= 1'b0;
            array_wdata_q     <= '0;
            result_valid_q    <= 1'b0;
            result_serial_q   <= '0;
            result_data_q     <= '0;
            response_valid_q  <= 1'b0;
            response_serial_q <= '0;
        end else begin
            phase_q           <= phase_d;
            lat_q             <= lat_d;
            rd_serial_q       <= rd_serial_d;
            wr_serial_q       <= wr_serial_d;
            cur_we_q          <= cur_we_d;
            cur_serial_q      <= cur_serial_d;
            array_index_q     <= array_index_d;
            array_we_q        <= array_we_d;
            array_wdata_q     <= array_wdata_d;
            result_valid_q    <= result_valid_d;
            result_serial_q   <= result_serial_d;
            result_data_q     <= result_data_d;
            response_valid_q  <= response_valid_d;
            response_serial_q <= response_serial_d;
        end
    end

    assign memReqAck      = !full_c;
    assign memSerial      = rd_serial_q;
    assign memWSerial     = wr_serial_q;
    assign resultValid    = result_valid_q;
    assign resultSerial   = result_serial_q;
    assign resultData     = result_data_q;
    assign responseValid  = response_valid_q;
    assign responseSerial = response_serial_q;
    assign arrayIndex     = array_index_q;
    assign arrayWE        = array_we_q;
    assign arrayWData     = array_wdata_q;

endmodule

// File: tb/tb_dcache_memory_responder.sv
// Bench for dcache_memory_responder: directed vectors, corner sequences and
// random traffic checked against an in-order transaction model.
module tb_dcache_memory_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         memValid = 1'b0;
    logic         memWE = 1'b0;
    logic [31:0]  memAddr = '0;
    logic [127:0] memData = '0;
    logic         memReqAck;
    logic [3:0]   memSerial, memWSerial, resultSerial, responseSerial;
    logic         resultValid, responseValid, arrayWE;
    logic [127:0] resultData, arrayWData;
    logic [127:0] arrayRData = '0;
    logic [9:0]   arrayIndex;

    dcache_memory_responder dut (
        .clk(clk), .rst(rst_n),
        .memValid(memValid), .memWE(memWE), .memAddr(memAddr), .memData(memData),
        .memReqAck(memReqAck), .memSerial(memSerial), .memWSerial(memWSerial),
        .resultValid(resultValid), .resultSerial(resultSerial), .resultData(resultData),
        .responseValid(responseValid), .responseSerial(responseSerial),
        .arrayIndex(arrayIndex), .arrayWE(arrayWE), .arrayWData(arrayWData),
        .arrayRData(arrayRData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line array attached to the DUT: registered read, read-before-write.
    logic [127:0] lines [1024];
    always @(posedge clk) begin
        arrayRData <= lines[arrayIndex];
        if (arrayWE) lines[arrayIndex] = arrayWData;
    end

    function automatic logic [127:0] init_line(input int i);
        if (i == 4) return {16{8'hA5}};
        return {8{16'(i)}};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: every accepted request responds LAT cycles after it
    // can start, which is one cycle after acceptance or after its predecessor.
    typedef struct {
        logic         we;
        logic [9:0]   idx;
        logic [127:0] data;
        logic [3:0]   serial;
        int           resp;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    logic [127:0] mmem [1024];
    logic [3:0]   m_rd = '0;
    logic [3:0]   m_wr = '0;
    int           last_resp = -100;
    int           mon_start;
    logic         mon_exp_r, mon_exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_result_valid", 128'(resultValid), 128'(0));
            chk("rst_response_valid", 128'(responseValid), 128'(0));
            chk("rst_array_we", 128'(arrayWE), 128'(0));
            chk("rst_rd_serial", 128'(memSerial), 128'(0));
            chk("rst_wr_serial", 128'(memWSerial), 128'(0));
            q.delete();
            m_rd      = '0;
            m_wr      = '0;
            last_resp = -100;
        end else begin
            chk("ack", 128'(memReqAck), 128'(q.size() < DEPTH));
            chk("rd_serial", 128'(memSerial), 128'(m_rd));
            chk("wr_serial", 128'(memWSerial), 128'(m_wr));
            mon_exp_r = 1'b0;
            mon_exp_w = 1'b0;
            if (q.size() > 0 && q[0].resp == cyc) begin
                mon_exp_r = !q[0].we;
                mon_exp_w = q[0].we;
            end
            chk("result_valid", 128'(resultValid), 128'(mon_exp_r));
            chk("response_valid", 128'(responseValid), 128'(mon_exp_w));
            if (mon_exp_r) begin
                chk("result_serial", 128'(resultSerial), 128'(q[0].serial));
                chk("result_data", resultData, mmem[q[0].idx]);
            end
            if (mon_exp_w) begin
                chk("response_serial", 128'(responseSerial), 128'(q[0].serial));
                mmem[q[0].idx] = q[0].data;
            end
            if (q.size() > 0 && q[0].resp == cyc) void'(q.pop_front());
            if (memValid && memReqAck) begin
                mon_e.we     = memWE;
                mon_e.idx    = memAddr[13:4];
                mon_e.data   = memData;
                mon_e.serial = memWE ? m_wr : m_rd;
                mon_start    = (cyc + 1 > last_resp + 1) ? cyc + 1 : last_resp + 1;
                mon_e.resp   = mon_start + LAT;
                last_resp    = mon_e.resp;
                if (memWE) m_wr = m_wr + 4'd1;
                else       m_rd = m_rd + 4'd1;
                q.push_back(mon_e);
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [127:0] d);
        @(posedge clk);
        #1;
        memValid = v;
        memWE    = we;
        memAddr  = a;
        memData  = d;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 128'(q.size()), 128'(0));
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [3:0]   exp_serial;
        logic [9:0]   exp_idx;
        logic [127:0] exp_data;
    } vec_t;

    vec_t         vt [7];
    int           exp_off [6] = '{0, 1, 2, 3, 6, 11};
    int           t0, lat, nacc, tw, tr;
    logic         got;
    logic [9:0]   widx;
    logic [3:0]   s0;
    logic [31:0]  ra;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            lines[i] = init_line(i);
            mmem[i]  = init_line(i);
        end
        vt[0] = '{1'b0, 32'h0000_0040, 128'h0,            4'd0, 10'd4,     {16{8'hA5}}};
        vt[1] = '{1'b1, 32'h0000_0080, {8{16'h1111}},     4'd0, 10'd8,     128'h0};
        vt[2] = '{1'b0, 32'h0000_0088, 128'h0,            4'd1, 10'd8,     {8{16'h1111}}};
        vt[3] = '{1'b1, 32'h0000_004C, {16{8'h5A}},       4'd1, 10'd4,     128'h0};
        vt[4] = '{1'b0, 32'hFFFF_C044, 128'h0,            4'd2, 10'd4,     {16{8'h5A}}};
        vt[5] = '{1'b0, 32'h0000_3FF0, 128'h0,            4'd3, 10'h3FF,   {8{16'h03FF}}};
        vt[6] = '{1'b0, 32'h0000_0000, 128'h0,            4'd4, 10'd0,     128'h0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Isolated transactions on an idle responder.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
            @(negedge clk);
            chk("vec_ack", 128'(memReqAck), 128'(1));
            chk("vec_serial", 128'(vt[i].we ? memWSerial : memSerial), 128'(vt[i].exp_serial));
            t0   = cyc;
            got  = 1'b0;
            lat  = 0;
            widx = '0;
            drive(1'b0, 1'b0, 32'h0, 128'h0);
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (arrayWE) widx = arrayIndex;
                if (resultValid || responseValid) begin
                    got = 1'b1;
                    lat = cyc - t0;
                    chk("vec_kind", 128'(responseValid), 128'(vt[i].we));
                    chk("vec_rserial", 128'(vt[i].we ? responseSerial : resultSerial), 128'(vt[i].exp_serial));
                    if (!vt[i].we) chk("vec_data", resultData, vt[i].exp_data);
                    else           chk("vec_windex", 128'(widx), 128'(vt[i].exp_idx));
                end
            end
            chk("vec_latency", 128'(lat), 128'(LAT + 1));
        end
        drain();

        // Write then read of the same line on consecutive cycles.
        drive(1'b1, 1'b1, 32'h0000_0080, {4{32'hCAFE_F00D}});
        drive(1'b1, 1'b0, 32'h0000_0080, 128'h0);
        drive(1'b0, 1'b0, 32'h0, 128'h0);
        tw = -1;
        tr = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (responseValid) tw = cyc;
            if (resultValid) begin
                tr = cyc;
                chk("wr_rd_data", resultData, {4{32'hCAFE_F00D}});
            end
        end
        chk("wr_rd_spacing", 128'(tr - tw), 128'(LAT + 1));
        drain();

        // Six back-to-back reads with memValid held: ack pattern across full.
        nacc = 0;
        t0   = 0;
        drive(1'b1, 1'b0, 32'h100, 128'h0);
        for (int k = 0; k < 60 && nacc < 6; k++) begin
            @(negedge clk);
            if (memReqAck) begin
                if (nacc == 0) t0 = cyc;
                chk("b2b_ack_offset", 128'(cyc - t0), 128'(exp_off[nacc]));
                nacc++;
            end
            @(posedge clk);
            #1;
            if (nacc == 6) memValid = 1'b0;
            else           memAddr  = 32'h100 + 32'(nacc) * 32'd16;
        end
        memValid = 1'b0;
        chk("b2b_accepted", 128'(nacc), 128'(6));
        drain();

        // Reset while the first of three queued reads is in WAIT.
        drive(1'b1, 1'b0, 32'h0000_0040, 128'h0);
        drive(1'b1, 1'b0, 32'h0000_0080, 128'h0);
        drive(1'b1, 1'b0, 32'h0000_3FF0, 128'h0);
        drive(1'b0, 1'b0, 32'h0, 128'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_result_valid", 128'(resultValid), 128'(0));
        chk("midrst_ack", 128'(memReqAck), 128'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0040, 128'h0);
        @(negedge clk);
        chk("postrst_ack", 128'(memReqAck), 128'(1));
        chk("postrst_serial", 128'(memSerial), 128'(0));
        drive(1'b0, 1'b0, 32'h0, 128'h0);
        drain();

        // Seventeen reads: the read serial wraps without a gap.
        nacc = 0;
        s0   = m_rd;
        drive(1'b1, 1'b0, 32'h200, 128'h0);
        for (int k = 0; k < 200 && nacc < 17; k++) begin
            @(negedge clk);
            if (memReqAck) begin
                chk("wrap_serial", 128'(memSerial), 128'(4'(s0 + 4'(nacc))));
                nacc++;
            end
            @(posedge clk);
            #1;
            if (nacc == 17) memValid = 1'b0;
            else            memAddr  = 32'h200 + 32'(nacc) * 32'd16;
        end
        memValid = 1'b0;
        chk("wrap_accepted", 128'(nacc), 128'(17));
        drain();

        // Random mixed traffic over a handful of lines.
        for (int i = 0; i < 400; i++) begin
            ra       = $urandom;
            ra[13:4] = 10'($urandom_range(0, 7));
            drive(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ra,
                  {$urandom, $urandom, $urandom, $urandom});
        end
        drive(1'b0, 1'b0, 32'h0, 128'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_memory_responder.md
Name: dcache_memory_responder

Overview:
- Memory-side responder for the D-cache line-request protocol: the far end of the memAddr/memData/memWE/memValid request channel.
- Acks requests and hands back read/write serials in the acceptance cycle; queues requests in order.
- Services each request against a single-port line array with configurable latency; returns read results and write responses tagged with those serials.
- Sits between the D-cache memory request multiplexer and the line-storage model or memory controller.

Parameters:
ADDR_WIDTH, 32, physical address width (PhyAddrPath)
LINE_WIDTH, 128, cache line width in bits (DCacheLinePath)
OFFSET_BITS, 4, log2 of line size in bytes; dropped from the address
INDEX_WIDTH, 10, line-array index width
SERIAL_WIDTH, 4, width of the read and write serials
QUEUE_DEPTH, 4, request queue entries (power of 2, at least 2)
MEM_LATENCY, 4, cycles from service start to response valid (at least 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
memValid  in  1  request valid
memWE  in  1  1 = line write, 0 = line read
memAddr  in  ADDR_WIDTH  request address
memData  in  LINE_WIDTH  write line data
memReqAck  out  1  request accepted this cycle when memValid is high
memSerial  out  SERIAL_WIDTH  serial assigned to a read accepted this cycle
memWSerial  out  SERIAL_WIDTH  serial assigned to a write accepted this cycle
resultValid  out  1  read data valid (memAccessResult.valid)
resultSerial  out  SERIAL_WIDTH  serial of the returned read
resultData  out  LINE_WIDTH  returned line
responseValid  out  1  write completion valid (memAccessResponse.valid)
responseSerial  out  SERIAL_WIDTH  serial of the completed write
arrayIndex  out  INDEX_WIDTH  line-array index
arrayWE  out  1  line-array write enable
arrayWData  out  LINE_WIDTH  line-array write data
arrayRData  in  LINE_WIDTH  line-array read data, registered, valid 1 cycle after a read

Behaviour:
Reset:
- Asserting rst low clears the queue, both serial counters, the FSM (to IDLE) and the latency counter.
- All valid outputs and arrayWE go to 0; the serial and data outputs go to 0.
- Reset mid-operation drops in-flight and queued requests silently.

Acceptance and serials:
- memReqAck = !full. It depends only on registered state, never on memValid.
- A request is accepted when memValid && memReqAck. When full, ack stays 0 even if the head retires in the same cycle.
- memSerial and memWSerial always show the current rdSerialCnt and wrSerialCnt values.
- An accepted read takes rdSerialCnt; an accepted write takes wrSerialCnt. The matching counter increments, wrapping modulo 2^SERIAL_WIDTH.
- Each queue entry holds {we, index = addr[OFFSET_BITS+INDEX_WIDTH-1:OFFSET_BITS], data, serial}.
- The queue is a circular buffer with wrapping head/tail pointers and a count.
- Push and pop in the same cycle leave the count unchanged.

Service FSM (one request at a time, strict queue order):
- IDLE: if the queue is non-empty, go to ACCESS.
- ACCESS (1 cycle): drive arrayIndex from the head entry.
  - Write: arrayWE = 1, arrayWData = entry data.
  - Read: arrayWE = 0.
  - Load latency counter = MEM_LATENCY-1, then go to WAIT.
- WAIT: decrement the counter each cycle. For a read, capture arrayRData in the first WAIT cycle. Go to RESPOND when the counter reaches 1.
- RESPOND (1 cycle):
  - Read: resultValid = 1 with the captured data and entry serial.
  - Write: responseValid = 1 with the entry serial.
  - Pop the head. Go to ACCESS if more entries remain, otherwise IDLE.
- Latency: a request accepted at cycle t into an empty, idle responder enters ACCESS at t+1 and responds at t+1+MEM_LATENCY.
- Back-to-back requests respond every MEM_LATENCY+1 cycles.
- resultValid and responseValid are 1-cycle pulses and never both high in the same cycle.
- A read following a write to the same index returns the new data, because ordering is strict.
- arrayIndex and arrayWData hold their last value outside ACCESS; arrayWE is 0 outside ACCESS.

Decomposition:
- Shared package entries:
  - MemAccessSerial, MemWriteSerial, DCacheLinePath and PhyAddrPath typedefs.
  - A MemResponderEntry struct {we, index, data, serial}.
  - A MemResponderPhase enum {IDLE, ACCESS, WAIT, RESPOND}.
  - The QUEUE_DEPTH and MEM_LATENCY defaults.
- Sub-module: mem_request_queue, a parameterized circular FIFO of MemResponderEntry with full/empty/count outputs. The FSM, serial counters and response registers stay in the top module.

Test Plan:
- Reset, then a single read of 0x0000_0040 at t (array holds 0xA5.. at index 4) -> memReqAck=1, memSerial=0 at t; resultValid=1 at t+5 with resultSerial=0 and resultData=0xA5..; no other valid pulses.
- Write 0x1111.. to 0x80, then read 0x80 in the next cycle -> memWSerial=0, memSerial=0; arrayWE=1 with arrayIndex=8; responseValid with serial 0 is followed 5 cycles later by resultValid with data 0x1111...
- Hold memValid high with 6 back-to-back reads -> ack for the first 4; ack stays 0 while full; the 5th request is acked the cycle after the first pop; results come in order with serials 0..5, spaced 5 cycles apart.
- Issue 17 reads -> serials 0..15, then 0: the counter wraps with no gap and results carry the matching wrapped serials.
- Assert rst low during WAIT with 3 entries queued -> all valids go to 0 immediately and no response appears after release; the next accepted read gets serial 0 and ack=1.
- Interleave read, write, read -> memSerial goes 0, 1 and memWSerial goes 0, advancing independently; responses arrive in issue order with no overlap of the valid pulses.
